mult_cu_16: RTL and testbench

Control unit for the 16-bit shift-add multiplier datapath (`mult_dp_16`). It sits directly upstream of the datapath and accepts a start request from the ALU. It sequences operand load, 16 conditional add-and-shift steps and completion using the datapath's `ls_bit` and `counterOut` feedback. It then reports completion to the ALU with a one-cycle done pulse.

---
 rtl/mult_cu_16_if.sv | 31 +++
 rtl/mult_cu_16.sv | 55 +++++
 tb/tb_mult_cu_16.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mult_cu_16_if.sv
// Control/feedback bundle between the multiplier control unit and the
// ALU + shift-add datapath it sequences.
interface mult_cu_16_if;
  logic       start;
  logic       ls_bit;
  logic [4:0] counterOut;
  logic       wr_shift_reg;
  logic       wr_counter;
  logic       sl_shift;
  logic       rt_shift_reg;
  logic       rt_counter;
  logic       rt_multiplicand;
  logic       busy;
  logic       done;

  // ALU/datapath side: issues start, returns feedback, consumes controls.
  modport master (
    output start, ls_bit, counterOut,
    input  wr_shift_reg, wr_counter, sl_shift,
    input  rt_shift_reg, rt_counter, rt_multiplicand,
    input  busy, done
  );

  // Control unit side.
  modport slave (
    input  start, ls_bit, counterOut,
    output wr_shift_reg, wr_counter, sl_shift,
    output rt_shift_reg, rt_counter, rt_multiplicand,
    output busy, done
  );
endinterface

// File: rtl/mult_cu_16.sv
// Control unit for the 16-bit shift-add multiplier datapath.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start, all outputs low
// LOAD  | clear counter, load multiplier and multiplicand (1 cycle)
// STEP  | one conditional add-and-shift per cycle, WIDTH cycles
// DONE  | product valid in the shift register, one-cycle done pulse
module mult_cu_16 #(
  parameter int WIDTH = 16
) (
  input logic          clock,
  input logic          reset_n,
  mult_cu_16_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] STEP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [4:0] LAST_STEP = 5'(WIDTH - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;

  // State register; reset forces IDLE without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode. STEP exits on >= so a corrupt counter cannot hang it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = STEP;
      STEP:    if (bus.counterOut >= LAST_STEP) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rt_shift_reg    = (state == LOAD);
  assign bus.rt_multiplicand = (state == LOAD);
  assign bus.rt_counter      = (state == LOAD);
  assign bus.sl_shift        = (state == STEP);
  assign bus.wr_counter      = (state == STEP);
  // Only Mealy output: add the multiplicand when the current multiplier bit is 1.
  assign bus.wr_shift_reg    = (state == STEP) && bus.ls_bit;
  assign bus.busy            = (state != IDLE);
  assign bus.done            = (state == DONE);

endmodule

// File: tb/tb_mult_cu_16.sv
// Bench for mult_cu_16 with a behavioural shift-add datapath attached.
module tb_mult_cu_16;

  logic clock = 1'b0;
  logic reset_n;

  mult_cu_16_if cu_if ();

  mult_cu_16 #(.WIDTH(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (cu_if.slave)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Datapath model
  logic [15:0] op_a, op_b;
  logic [15:0] mc;
  logic [31:0] sr;
  logic [4:0]  cnt;
  logic        force_cnt;
  logic [16:0] sum17;

  assign cu_if.ls_bit     = sr[0];
  assign cu_if.counterOut = force_cnt ? 5'd20 : cnt;

  always @(posedge clock) begin
    if (cu_if.rt_shift_reg)    sr  <= {16'b0, op_b};
    if (cu_if.rt_multiplicand) mc  <= op_a;
    if (cu_if.rt_counter)      cnt <= 5'd0;
    if (cu_if.wr_counter)      cnt <= cnt + 5'd1;
    if (cu_if.sl_shift) begin
      sum17 = cu_if.wr_shift_reg ? ({1'b0, sr[31:16]} + {1'b0, mc}) : {1'b0, sr[31:16]};
      sr <= {sum17, sr[15:1]};
    end
  end

  // {rt_shift_reg, rt_multiplicand, rt_counter, sl_shift, wr_counter, wr_shift_reg, busy, done}
  function automatic logic [31:0] obs_vec();
    return {24'b0, cu_if.rt_shift_reg, cu_if.rt_multiplicand, cu_if.rt_counter,
            cu_if.sl_shift, cu_if.wr_counter, cu_if.wr_shift_reg, cu_if.busy, cu_if.done};
  endfunction

  // Reference: p = cycles since the accepting edge (0 LOAD, 1..16 steps, 17 done, 18 idle).
  function automatic logic [31:0] exp_vec(int p, logic [15:0] b);
    logic [7:0] v;
    v = 8'b0;
    if (p == 0)                 v = 8'b1110_0010;
    else if (p >= 1 && p <= 16) v = {3'b000, 1'b1, 1'b1, b[p-1], 1'b1, 1'b0};
    else if (p == 17)           v = 8'b0000_0011;
    return {24'b0, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation from a negedge in IDLE. extra_k: cycle to re-pulse start;
  // force_k: cycle at which counterOut is forced out of range.
  task automatic run_mult(input logic [15:0] a, input logic [15:0] b,
                          input int extra_k, input int force_k);
    int p;
    op_a = a;
    op_b = b;
    cu_if.start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k == 0) cu_if.start = 1'b0;
      if (force_k > 0 && k > force_k) p = (k == force_k + 1) ? 17 : 18;
      else                            p = k;
      check($sformatf("op_k%0d", k), obs_vec(), exp_vec(p, b));
      if (p == 17 && force_k < 0)
        check("result", sr, {16'b0, a} * {16'b0, b});
      if (k == extra_k)     cu_if.start = 1'b1;
      if (k == extra_k + 1) cu_if.start = 1'b0;
      if (k == force_k)     force_cnt = 1'b1;
      if (p == 18) break;
    end
    force_cnt = 1'b0;
    cu_if.start = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb;
    int p;
    reset_n     = 1'b0;
    force_cnt   = 1'b0;
    cu_if.start = 1'b1;
    op_a = 16'd3;
    op_b = 16'd5;
    sr   = 32'b0;
    mc   = 16'b0;
    cnt  = 5'b0;

    // Reset held with start high: nothing moves.
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      check("reset_outputs", obs_vec(), 32'b0);
    end

    // Release with start still high: accepted on the first edge.
    reset_n = 1'b1;
    run_mult(16'd3, 16'd5, -1, -1);

    // Zero multiplier.
    run_mult(16'hABCD, 16'd0, -1, -1);

    // Start re-pulsed during step 5 is ignored.
    run_mult(16'(($urandom)), 16'(($urandom)), 6, -1);

    // Random operands.
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_mult(ra, rb, -1, -1);
    end
    run_mult(16'hFFFF, 16'hFFFF, -1, -1);

    // Out-of-range counter during STEP terminates on the next edge.
    run_mult(16'(($urandom)), 16'(($urandom)), -1, 3);

    // Back-to-back with start held high for 40 edges.
    op_a = 16'(($urandom));
    op_b = 16'(($urandom));
    cu_if.start = 1'b1;
    for (int k = 0; k < 57; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k == 39) cu_if.start = 1'b0;
      p = k % 19;
      check($sformatf("b2b_k%0d", k), obs_vec(), exp_vec(p, op_b));
      if (p == 17) check("b2b_result", sr, {16'b0, op_a} * {16'b0, op_b});
    end

    // Asynchronous reset during step 8.
    op_a = 16'(($urandom));
    op_b = 16'(($urandom));
    cu_if.start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k == 0) cu_if.start = 1'b0;
      check($sformatf("pre_rst_k%0d", k), obs_vec(), exp_vec(k, op_b));
    end
    #2 reset_n = 1'b0;
    #1 check("async_reset_drop", obs_vec(), 32'b0);
    @(posedge clock);
    @(negedge clock);
    check("reset_hold", obs_vec(), 32'b0);
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("post_reset_idle", obs_vec(), 32'b0);
    run_mult(16'd7, 16'd9, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
